// File: rtl/comp_seq_nb.sv
// rtl/comp_seq_nb.sv - chunked sequential magnitude comparator with valid/ready handshakes
// Optional feature macro: COMP_SEQ_SIGNED_EN (two's complement operands when defined)

module comp_seq_nb #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Operand registers shift left one chunk per equal step, so the chunk
  // under test always sits in the top CHUNK bits; idx tracks how far we are.
  logic [WIDTH-1:0] ra, rb;
  logic [IDX_W-1:0] idx;
  logic             eq_r, gt_r, lt_r;

  logic [WIDTH-1:0] a_lat, b_lat;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             accept;
  logic             chunk_ne;
  logic             last_chunk;

  assign accept     = in_valid && (state == S_IDLE);
  assign chunk_a    = ra[WIDTH-1 -: CHUNK];
  assign chunk_b    = rb[WIDTH-1 -: CHUNK];
  assign chunk_ne   = (chunk_a != chunk_b);
  assign last_chunk = (idx == LAST_IDX);

  // Operand conditioning at the accept handshake
  always_comb begin
    a_lat = a;
    b_lat = b;
`ifdef COMP_SEQ_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    a_lat[WIDTH-1] = ~a[WIDTH-1];
    b_lat[WIDTH-1] = ~b[WIDTH-1];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_CMP;
      S_CMP:  if (chunk_ne || last_chunk) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, walk chunks MSB first in CMP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      idx  <= '0;
      eq_r <= 1'b0;
      gt_r <= 1'b0;
      lt_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ra   <= a_lat;
            rb   <= b_lat;
            idx  <= '0;
            eq_r <= 1'b0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
          end
        end
        S_CMP: begin
          if (chunk_ne) begin
            eq_r <= 1'b0;
            gt_r <= (chunk_a > chunk_b);
            lt_r <= (chunk_a < chunk_b);
          end else if (last_chunk) begin
            eq_r <= 1'b1;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
          end else begin
            ra  <= ra << CHUNK;
            rb  <= rb << CHUNK;
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; result flags are gated so they read zero outside DONE
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_CMP) || (state == S_DONE);
    eq        = out_valid && eq_r;
    gt        = out_valid && gt_r;
    lt        = out_valid && lt_r;
  end

endmodule

// File: tb/tb_comp_seq_nb.sv
// tb/tb_comp_seq_nb.sv - randomized self-checking bench for comp_seq_nb

module tb_comp_seq_nb;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int NC = W / C;
  localparam int MAX_WAIT = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         eq, gt, lt, busy;

  int n_cmp = 0;
  int n_fail = 0;

  comp_seq_nb #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .gt(gt), .lt(lt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: ordering from plain integer compare, latency from the first
  // differing chunk counted from the MSB.
  function automatic int ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy;
`ifdef COMP_SEQ_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    if (sx > sy) return 1;
    if (sx < sy) return -1;
    return 0;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, cx, cy;
    ux = int'(x);
    uy = int'(y);
`ifdef COMP_SEQ_SIGNED_EN
    ux = ux ^ (1 << (W - 1));
    uy = uy ^ (1 << (W - 1));
`endif
    for (int k = 0; k < NC; k++) begin
      cx = (ux >> (W - (k + 1) * C)) % (1 << C);
      cy = (uy >> (W - (k + 1) * C)) % (1 << C);
      if (cx != cy) return k + 1;
    end
    return NC;
  endfunction

  // Drive one accept and wait for out_valid; no checking here.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output logic re, output logic rg, output logic rl);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    re = eq;
    rg = gt;
    rl = lt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({eq, gt, lt} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {eq, gt, lt}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat, exp_lat, rel;
    logic re, rg, rl;
    logic [2:0] exp_f;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_before: got %b want 1", name, in_ready); end
    run_op(x, y, lat, re, rg, rl);
    exp_lat = ref_lat(x, y);
    rel = ref_cmp(x, y);
    exp_f = (rel == 0) ? 3'b100 : (rel > 0) ? 3'b010 : 3'b001;
    n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency a=%h b=%h: got %0d want %0d", name, x, y, lat, exp_lat); end
    n_cmp++; if ({re, rg, rl} !== exp_f) begin n_fail++; $display("FAIL %s_result a=%h b=%h: got %b want %b", name, x, y, {re, rg, rl}, exp_f); end
    @(posedge clk);
    #1;
    n_cmp++; if ({in_ready, out_valid, eq, gt, lt} !== 5'b10000) begin
      n_fail++; $display("FAIL %s_return_idle: got %b want 10000", name, {in_ready, out_valid, eq, gt, lt});
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    check_op("equal_a5", 8'hA5, 8'hA5);
    check_op("msb_diff", 8'h80, 8'h7F);
    check_op("lsb_diff", 8'h12, 8'h13);
    check_op("neg_pair", 8'hFF, 8'hFE);
    check_op("zero_zero", 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = (i % 4 == 0) ? x : ((i % 4 == 1) ? (x ^ W'(1 << $urandom_range(W - 1, 0))) : W'($urandom));
      check_op("random", x, y);
    end
  endtask

  task automatic test_backpressure();
    int lat, exp_lat;
    logic re, rg, rl;
    out_ready = 1'b0;
    a = 8'h40;
    b = 8'h41;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = ref_lat(8'h40, 8'h41);
    n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat); end
    a = 8'h55;
    b = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if ({out_valid, in_ready, eq, gt, lt} !== 5'b10001) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got %b want 10001", i, {out_valid, in_ready, eq, gt, lt});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b want 10", {in_ready, out_valid}); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    re = eq; rg = gt; rl = lt;
    n_cmp++; if (lat != ref_lat(8'h55, 8'h55)) begin n_fail++; $display("FAIL bp_next_latency: got %0d want %0d", lat, ref_lat(8'h55, 8'h55)); end
    n_cmp++; if ({re, rg, rl} !== 3'b100) begin n_fail++; $display("FAIL bp_next_result: got %b want 100", {re, rg, rl}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, eq, gt, lt, busy} !== 5'b00000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b want 00000", {out_valid, eq, gt, lt, busy});
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL midreset_stale: got stale activity want none"); end
    check_op("after_reset", 8'h3C, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
